// File: rtl/pe_noc_adapter_if.sv
// rtl/pe_noc_adapter_if.sv - NoC and miner-side signal bundle for pe_noc_adapter
// Purpose: groups the NoC flit/credit ports and the miner handshake ports.
// Ports:
//   getFlit / EN_getFlit        incoming flit {valid, tail, dest, vc, data}, receive enable
//   putCredits / EN_putCredits  credit returned to the network {valid, vc}, strobe
//   putFlit / EN_putFlit        outgoing flit, strobe
//   getCredits / EN_getCredits  credit from the network {valid, vc}, receive enable
//   header / header_valid / header_ack   assembled block header to the miner
//   found / found_nonce         miner success pulse and nonce
//   err_frame                   malformed-packet pulse
// Modports: slave = adapter side, master = network/miner environment side.
interface pe_noc_adapter_if #(
  parameter int FLIT_DATA_WIDTH = 64,
  parameter int DEST_BITS       = 5,
  parameter int VC_BITS         = 2,
  parameter int HDR_FLITS       = 10
);
  localparam int FLIT_W = 2 + DEST_BITS + VC_BITS + FLIT_DATA_WIDTH;
  localparam int CRED_W = 1 + VC_BITS;
  localparam int HDR_W  = HDR_FLITS * FLIT_DATA_WIDTH;

  logic [FLIT_W-1:0] getFlit;
  logic              EN_getFlit;
  logic [CRED_W-1:0] putCredits;
  logic              EN_putCredits;
  logic [FLIT_W-1:0] putFlit;
  logic              EN_putFlit;
  logic [CRED_W-1:0] getCredits;
  logic              EN_getCredits;
  logic [HDR_W-1:0]  header;
  logic              header_valid;
  logic              header_ack;
  logic              found;
  logic [31:0]       found_nonce;
  logic              err_frame;

  modport slave (
    input  getFlit, getCredits, header_ack, found, found_nonce,
    output EN_getFlit, putCredits, EN_putCredits, putFlit, EN_putFlit,
           EN_getCredits, header, header_valid, err_frame
  );

  modport master (
    output getFlit, getCredits, header_ack, found, found_nonce,
    input  EN_getFlit, putCredits, EN_putCredits, putFlit, EN_putFlit,
           EN_getCredits, header, header_valid, err_frame
  );
endinterface

// File: rtl/pe_noc_adapter.sv
// rtl/pe_noc_adapter.sv - PE-side NoC adapter: header reassembly, search timing, result return
// Purpose: reassembles HDR_FLITS header flits into one block header, hands it to
// the miner, times the search from ack to found, and returns found/nonce/count
// flits to the controller under credit flow control.
// Ports:
//   sys_clk  clock
//   nreset   asynchronous active-low reset
//   bus      pe_noc_adapter_if.slave (flit, credit and miner handshake signals)
module pe_noc_adapter #(
  parameter int FLIT_DATA_WIDTH = 64,
  parameter int DEST_BITS       = 5,
  parameter int VC_BITS         = 2,
  parameter int MY_ADDR         = 1,
  parameter int CTRL_ADDR       = 0,
  parameter int HDR_FLITS       = 10,
  parameter int CREDIT_INIT     = 16
) (
  input  logic                 sys_clk,
  input  logic                 nreset,
  pe_noc_adapter_if.slave      bus
);
  localparam int FLIT_W    = 2 + DEST_BITS + VC_BITS + FLIT_DATA_WIDTH;
  localparam int HDR_W     = HDR_FLITS * FLIT_DATA_WIDTH;
  localparam int IDX_W     = $clog2(HDR_FLITS);
  localparam int CRD_W     = $clog2(CREDIT_INIT + 1);
  localparam int VC_LSB    = FLIT_DATA_WIDTH;
  localparam int DEST_LSB  = VC_LSB + VC_BITS;
  localparam int TAIL_BIT  = DEST_LSB + DEST_BITS;
  localparam int VALID_BIT = TAIL_BIT + 1;

  typedef enum logic [2:0] {TX_IDLE, TX_FOUND, TX_NONCE, TX_CLKS, TX_DONE} tx_state_t;

  // RX field decode
  logic                       w_rx_valid, w_rx_tail, w_rx_mine, w_last, w_complete, w_err;
  logic [DEST_BITS-1:0]       w_rx_dest;
  logic [VC_BITS-1:0]         w_rx_vc;
  logic [FLIT_DATA_WIDTH-1:0] w_rx_data;
  logic [HDR_W-1:0]           w_buf_next;

  logic [HDR_W-1:0]           r_buf, r_header;
  logic [IDX_W-1:0]           r_idx;
  logic                       r_hv, r_err, r_en_getflit, r_credit_en;
  logic [VC_BITS:0]           r_credit;

  // Search timer and TX
  logic [63:0]                r_cnt, r_count, w_cnt_inc, w_cnt_capture;
  logic                       r_running, w_ack_edge, w_capture;
  logic [31:0]                r_nonce;
  tx_state_t                  r_state, w_state_next;
  logic                       w_send, w_credit_ok, w_credit_in;
  logic [FLIT_DATA_WIDTH-1:0] w_tx_data;
  logic [FLIT_W-1:0]          r_put_flit;
  logic                       r_put_en;
  logic [CRD_W-1:0]           r_credits;
  logic                       w_unused_vc;

  assign w_rx_valid = bus.getFlit[VALID_BIT];
  assign w_rx_tail  = bus.getFlit[TAIL_BIT];
  assign w_rx_dest  = bus.getFlit[DEST_LSB +: DEST_BITS];
  assign w_rx_vc    = bus.getFlit[VC_LSB +: VC_BITS];
  assign w_rx_data  = bus.getFlit[FLIT_DATA_WIDTH-1:0];
  assign w_rx_mine  = w_rx_valid && (w_rx_dest == DEST_BITS'(MY_ADDR));
  assign w_last     = (r_idx == IDX_W'(HDR_FLITS - 1));
  assign w_complete = w_rx_mine && w_rx_tail && w_last;
  // Malformed: tail arriving early, or a non-tail flit where the tail must be
  assign w_err      = w_rx_mine && (w_rx_tail != w_last);

  // Buffer image with the current flit merged in, so the tail flit lands in header directly
  always_comb begin
    w_buf_next = r_buf;
    for (int i = 0; i < HDR_FLITS; i++) begin
      if (r_idx == IDX_W'(i)) w_buf_next[i*FLIT_DATA_WIDTH +: FLIT_DATA_WIDTH] = w_rx_data;
    end
  end

  always_ff @(posedge sys_clk or negedge nreset) begin
    if (!nreset) begin
      r_buf        <= '0;
      r_header     <= '0;
      r_idx        <= '0;
      r_hv         <= 1'b0;
      r_err        <= 1'b0;
      r_en_getflit <= 1'b0;
      r_credit_en  <= 1'b0;
      r_credit     <= '0;
    end else begin
      r_en_getflit <= 1'b1;
      r_credit_en  <= w_rx_valid;
      r_credit     <= w_rx_valid ? {1'b1, w_rx_vc} : '0;
      r_err        <= w_err;
      if (w_rx_mine) begin
        if (w_complete || w_err) begin
          r_idx <= '0;
        end else begin
          r_buf <= w_buf_next;
          r_idx <= r_idx + IDX_W'(1);
        end
      end
      // A fresh header takes precedence over an ack in the same cycle
      if (w_complete) begin
        r_header <= w_buf_next;
        r_hv     <= 1'b1;
      end else if (bus.header_ack) begin
        r_hv <= 1'b0;
      end
    end
  end

  // Search timer: counts edges after the ack edge; capture includes the found edge itself
  assign w_ack_edge    = r_hv && bus.header_ack;
  assign w_capture     = (r_state == TX_IDLE) && bus.found;
  assign w_cnt_inc     = r_running ? r_cnt + 64'd1 : r_cnt;
  assign w_cnt_capture = w_ack_edge ? 64'd0 : w_cnt_inc;

  always_ff @(posedge sys_clk or negedge nreset) begin
    if (!nreset) begin
      r_cnt     <= '0;
      r_running <= 1'b0;
      r_count   <= '0;
      r_nonce   <= '0;
    end else begin
      if (w_ack_edge) begin
        r_cnt     <= '0;
        r_running <= 1'b1;
      end else if (w_capture) begin
        r_cnt     <= w_cnt_inc;
        r_running <= 1'b0;
      end else begin
        r_cnt <= w_cnt_inc;
      end
      if (w_capture) begin
        r_nonce <= bus.found_nonce;
        r_count <= w_cnt_capture;
      end
    end
  end

  // TX FSM: state register
  always_ff @(posedge sys_clk or negedge nreset) begin
    if (!nreset) r_state <= TX_IDLE;
    else         r_state <= w_state_next;
  end

  assign w_credit_ok = (r_credits != '0);

  // TX FSM: next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      TX_IDLE:  if (bus.found) w_state_next = TX_FOUND;
      TX_FOUND: if (w_credit_ok) w_state_next = TX_NONCE;
      TX_NONCE: if (w_credit_ok) w_state_next = TX_CLKS;
      TX_CLKS:  if (w_credit_ok) w_state_next = TX_DONE;
      TX_DONE:  w_state_next = TX_DONE;
      default:  w_state_next = TX_IDLE;
    endcase
  end

  // TX FSM: outputs
  always_comb begin
    w_send    = 1'b0;
    w_tx_data = '0;
    case (r_state)
      TX_FOUND: begin w_send = w_credit_ok; w_tx_data = FLIT_DATA_WIDTH'(1); end
      TX_NONCE: begin w_send = w_credit_ok; w_tx_data = FLIT_DATA_WIDTH'(r_nonce); end
      TX_CLKS:  begin w_send = w_credit_ok; w_tx_data = FLIT_DATA_WIDTH'(r_count); end
      default:  ;
    endcase
  end

  // Only getCredits valid matters; all returned credits share one pool
  assign w_credit_in = bus.getCredits[VC_BITS];
  assign w_unused_vc = ^bus.getCredits[VC_BITS-1:0];

  always_ff @(posedge sys_clk or negedge nreset) begin
    if (!nreset) begin
      r_put_en   <= 1'b0;
      r_put_flit <= '0;
      r_credits  <= CRD_W'(CREDIT_INIT);
    end else begin
      r_put_en   <= w_send;
      r_put_flit <= w_send ? {1'b1, 1'b1, DEST_BITS'(CTRL_ADDR), {VC_BITS{1'b0}}, w_tx_data} : '0;
      case ({w_credit_in, w_send})
        2'b10:   if (r_credits != CRD_W'(CREDIT_INIT)) r_credits <= r_credits + CRD_W'(1);
        2'b01:   r_credits <= r_credits - CRD_W'(1);
        default: ;
      endcase
    end
  end

  assign bus.EN_getFlit    = r_en_getflit;
  assign bus.putCredits    = r_credit;
  assign bus.EN_putCredits = r_credit_en;
  assign bus.putFlit       = r_put_flit;
  assign bus.EN_putFlit    = r_put_en;
  assign bus.EN_getCredits = 1'b1;
  assign bus.header        = r_header;
  assign bus.header_valid  = r_hv;
  assign bus.err_frame     = r_err;
endmodule

// File: tb/tb_pe_noc_adapter.sv
// tb/tb_pe_noc_adapter.sv - directed self-checking bench for pe_noc_adapter
module tb_pe_noc_adapter;
  logic sys_clk = 1'b0;
  logic nreset  = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_cred;

  always #5 sys_clk = ~sys_clk;

  pe_noc_adapter_if bus0 ();
  pe_noc_adapter_if bus1 ();

  pe_noc_adapter u_dut (.sys_clk(sys_clk), .nreset(nreset), .bus(bus0));
  pe_noc_adapter #(.CREDIT_INIT(1)) u_dut1 (.sys_clk(sys_clk), .nreset(nreset), .bus(bus1));

  function automatic logic [72:0] mk_flit(input logic tail, input logic [4:0] dest,
                                          input logic [1:0] vc, input logic [63:0] data);
    return {1'b1, tail, dest, vc, data};
  endfunction

  task automatic check(input string tag, input logic [639:0] obs, input logic [639:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic set_flit(input logic [72:0] f);
    bus0.getFlit = f;
    bus1.getFlit = f;
  endtask

  initial begin
    set_flit('0);
    bus0.getCredits = '0;  bus1.getCredits = '0;
    bus0.header_ack = 1'b0; bus1.header_ack = 1'b0;
    bus0.found = 1'b0;      bus1.found = 1'b0;
    bus0.found_nonce = '0;  bus1.found_nonce = '0;

    // Reset state
    #1;
    check("rst_en_getflit", 640'(bus0.EN_getFlit), 640'(0));
    check("rst_en_getcredits", 640'(bus0.EN_getCredits), 640'(1));
    check("rst_header_valid", 640'(bus0.header_valid), 640'(0));
    check("rst_en_putflit", 640'(bus0.EN_putFlit), 640'(0));
    check("rst_putcredits", 640'({bus0.EN_putCredits, bus0.putCredits}), 640'(0));
    step();
    nreset = 1'b1;
    step();
    check("en_getflit_after_rst", 640'(bus0.EN_getFlit), 640'(1));

    // Early tail on 4th flit, vc 2 on one flit, then a foreign-dest flit
    for (int i = 0; i < 4; i++) begin
      set_flit(mk_flit(i == 3, 5'd1, (i == 1) ? 2'd2 : 2'd0, 64'hE0 + 64'(i)));
      step();
      if (i == 1) check("credit_vc2", 640'({bus0.EN_putCredits, bus0.putCredits}), 640'(4'b1110));
    end
    check("err_frame_early_tail", 640'(bus0.err_frame), 640'(1));
    check("hv_after_err", 640'(bus0.header_valid), 640'(0));
    set_flit(mk_flit(1'b0, 5'd2, 2'd1, 64'hBAD));
    step();
    check("err_frame_pulse_end", 640'(bus0.err_frame), 640'(0));
    check("credit_foreign", 640'({bus0.EN_putCredits, bus0.putCredits}), 640'(4'b1101));
    set_flit('0);
    step();
    check("no_credit_idle", 640'({bus0.EN_putCredits, bus0.putCredits}), 640'(0));

    // Good packet A0..A9
    n_cred = 0;
    for (int i = 0; i < 10; i++) begin
      set_flit(mk_flit(i == 9, 5'd1, 2'd0, 64'hA0 + 64'(i)));
      step();
      if (bus0.EN_putCredits && bus0.putCredits == 3'b100) n_cred++;
      if (i == 8) check("hv_before_tail", 640'(bus0.header_valid), 640'(0));
    end
    set_flit('0);
    check("credits_returned", 640'(n_cred), 640'(10));
    check("hv_after_tail", 640'(bus0.header_valid), 640'(1));
    check("hdr_lo", 640'(bus0.header[63:0]), 640'(64'hA0));
    check("hdr_hi", 640'(bus0.header[639:576]), 640'(64'hA9));
    check("hdr_mid", 640'(bus0.header[319:256]), 640'(64'hA4));
    check("hv_dut1", 640'(bus1.header_valid), 640'(1));

    // Ack at t0, found at t0+100
    bus0.header_ack = 1'b1; bus1.header_ack = 1'b1;
    step();
    bus0.header_ack = 1'b0; bus1.header_ack = 1'b0;
    check("hv_after_ack", 640'(bus0.header_valid), 640'(0));
    repeat (99) step();
    bus0.found = 1'b1; bus1.found = 1'b1;
    bus0.found_nonce = 32'hDEADBEEF; bus1.found_nonce = 32'hDEADBEEF;
    step();
    bus0.found = 1'b0; bus1.found = 1'b0;
    check("no_flit_at_found", 640'(bus0.EN_putFlit), 640'(0));
    bus0.getCredits = 3'b100;
    step();
    bus0.getCredits = '0;
    check("tx0_found_en", 640'(bus0.EN_putFlit), 640'(1));
    check("tx0_found_flit", 640'(bus0.putFlit), 640'(mk_flit(1'b1, 5'd0, 2'd0, 64'h1)));
    check("credits_send_plus_credit", 640'(u_dut.r_credits), 640'(16));
    check("tx1_found_flit", 640'(bus1.putFlit), 640'(mk_flit(1'b1, 5'd0, 2'd0, 64'h1)));
    step();
    check("tx0_nonce_flit", 640'(bus0.putFlit), 640'(mk_flit(1'b1, 5'd0, 2'd0, 64'hDEADBEEF)));
    check("tx1_stall_a", 640'(bus1.EN_putFlit), 640'(0));
    step();
    check("tx0_count_flit", 640'(bus0.putFlit), 640'(mk_flit(1'b1, 5'd0, 2'd0, 64'd100)));
    check("tx1_stall_b", 640'(bus1.EN_putFlit), 640'(0));
    check("credits_after_tx", 640'(u_dut.r_credits), 640'(14));
    bus1.getCredits = 3'b100;
    step();
    bus1.getCredits = '0;
    check("tx0_done_idle", 640'({bus0.EN_putFlit, bus0.putFlit}), 640'(0));
    check("tx1_stall_c", 640'(bus1.EN_putFlit), 640'(0));
    step();
    check("tx1_nonce_en", 640'(bus1.EN_putFlit), 640'(1));
    check("tx1_nonce_flit", 640'(bus1.putFlit), 640'(mk_flit(1'b1, 5'd0, 2'd0, 64'hDEADBEEF)));

    // Credit saturation
    bus0.getCredits = 3'b100;
    repeat (3) step();
    bus0.getCredits = '0;
    check("credits_saturate", 640'(u_dut.r_credits), 640'(16));

    // Second found after TX_DONE is ignored
    bus0.found = 1'b1;
    step();
    bus0.found = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("no_flit_after_done", 640'(bus0.EN_putFlit), 640'(0));
    end

    // Async reset after 5th flit
    for (int i = 0; i < 5; i++) begin
      set_flit(mk_flit(1'b0, 5'd1, 2'd0, 64'hB0 + 64'(i)));
      step();
    end
    set_flit('0);
    check("credit_before_rst", 640'(bus0.EN_putCredits), 640'(1));
    nreset = 1'b0;
    #1;
    check("arst_putcredits", 640'({bus0.EN_putCredits, bus0.putCredits}), 640'(0));
    check("arst_en_getflit", 640'(bus0.EN_getFlit), 640'(0));
    check("arst_header", 640'(bus0.header), 640'(0));
    check("arst_tx1", 640'({bus1.EN_putFlit, bus1.putFlit}), 640'(0));
    check("arst_en_getcredits", 640'(bus0.EN_getCredits), 640'(1));
    step();
    nreset = 1'b1;
    step();
    check("idle_after_rst", 640'({bus0.EN_putCredits, bus0.EN_putFlit, bus0.err_frame}), 640'(0));
    for (int i = 0; i < 10; i++) begin
      set_flit(mk_flit(i == 9, 5'd1, 2'd0, 64'hC0 + 64'(i)));
      step();
    end
    set_flit('0);
    check("post_rst_hv", 640'(bus0.header_valid), 640'(1));
    check("post_rst_err", 640'(bus0.err_frame), 640'(0));
    check("post_rst_hdr_lo", 640'(bus0.header[63:0]), 640'(64'hC0));
    check("post_rst_hdr_hi", 640'(bus0.header[639:576]), 640'(64'hC9));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
